// File: rtl/map_pkg.sv
// Shared definitions for the map RAM access path: geometry, cell and heading
// codes, arbiter state encoding and coordinate helpers.
package map_pkg;

  localparam int ROWS   = 10;
  localparam int COLS   = 20;
  localparam int CELL_W = 4;
  localparam int CELLS  = ROWS * COLS;
  localparam int ADDR_W = 8;
  localparam int ROW_W  = 4;
  localparam int COL_W  = 5;

  localparam logic [CELL_W-1:0] CELL_FREE     = 4'd0;
  localparam logic [CELL_W-1:0] CELL_WALL     = 4'd1;
  localparam logic [CELL_W-1:0] CELL_BLACK    = 4'd2;
  localparam logic [CELL_W-1:0] CELL_DEBRIS_L = 4'd3;
  localparam logic [CELL_W-1:0] CELL_DEBRIS_M = 4'd4;
  localparam logic [CELL_W-1:0] CELL_DEBRIS_H = 4'd5;

  localparam logic [3:0] DIR_N = 4'd0;
  localparam logic [3:0] DIR_W = 4'd1;
  localparam logic [3:0] DIR_S = 4'd2;
  localparam logic [3:0] DIR_E = 4'd3;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    IDLE = 2'd1,
    RD   = 2'd2,
    WR   = 2'd3
  } map_state_t;

  function automatic logic in_range(input logic [ROW_W-1:0] row, input logic [COL_W-1:0] col);
    return (int'(row) < ROWS) && (int'(col) < COLS);
  endfunction

  // Only meaningful for in-range coordinates, where the result fits 0..199.
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] row,
                                                  input logic [COL_W-1:0] col);
    return ADDR_W'(row) * ADDR_W'(COLS) + ADDR_W'(col);
  endfunction

endpackage

// File: rtl/map_ram.sv
// Single-port synchronous map RAM with registered read data; written so that
// synthesis maps it onto a block RAM.
module map_ram #(
  parameter int DEPTH  = 200,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_reg;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (re) begin
      rdata_reg <= mem[addr];
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/map_access_arbiter.sv
// Arbitrates the shared map RAM between the display reader and the map updater,
// clears the map after reset and double-buffers the robot pose per frame.
module map_access_arbiter
  import map_pkg::*;
#(
  parameter int STARVE_LIMIT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rd_req,
  input  logic [3:0] rd_row,
  input  logic [4:0] rd_col,
  output logic       rd_valid,
  output logic [3:0] rd_data,
  output logic       rd_miss,
  input  logic       wr_req,
  input  logic [3:0] wr_row,
  input  logic [4:0] wr_col,
  input  logic [3:0] wr_data,
  output logic       wr_ack,
  output logic       wr_err,
  input  logic       pose_wr,
  input  logic [3:0] pose_x,
  input  logic [3:0] pose_y,
  input  logic [3:0] pose_d,
  input  logic       frame_start,
  output logic [3:0] xr_o,
  output logic [3:0] yr_o,
  output logic [3:0] dr_o,
  output logic       init_done
);

  localparam int SC_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [SC_W-1:0]   STARVE_MAX = SC_W'(STARVE_LIMIT);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(CELLS - 1);

  map_state_t        state_reg, state_next;
  logic [ADDR_W-1:0] init_addr_reg, init_addr_next;
  logic [SC_W-1:0]   starve_reg, starve_next;

  logic              rd_grant, wr_grant, starved;
  logic              rd_in_range, wr_in_range;
  logic [ADDR_W-1:0] rd_addr, wr_addr;

  logic              ram_we, ram_re;
  logic [ADDR_W-1:0] ram_addr;
  logic [CELL_W-1:0] ram_wdata, ram_q;

  logic              rd_p1_reg, rd_oor_p1_reg;
  logic              rd_valid_reg, wr_ack_reg, wr_err_reg, init_done_reg;
  logic [CELL_W-1:0] rd_data_reg;

  assign rd_in_range = in_range(rd_row, rd_col);
  assign wr_in_range = in_range(wr_row, wr_col);
  assign rd_addr     = cell_addr(rd_row, rd_col);
  assign wr_addr     = cell_addr(wr_row, wr_col);
  assign starved     = (starve_reg == STARVE_MAX);

  map_ram #(
    .DEPTH (CELLS),
    .ADDR_W(ADDR_W),
    .DATA_W(CELL_W)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .re   (ram_re),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .rdata(ram_q)
  );

  // Grants are gated by rst so an access coinciding with reset never lands.
  always_comb begin
    state_next     = state_reg;
    init_addr_next = init_addr_reg;
    starve_next    = starve_reg;
    rd_grant       = 1'b0;
    wr_grant       = 1'b0;
    rd_miss        = 1'b0;
    ram_we         = 1'b0;
    ram_re         = 1'b0;
    ram_addr       = '0;
    ram_wdata      = CELL_FREE;
    if (rst) begin
      if (state_reg == INIT) begin
        ram_we   = 1'b1;
        ram_addr = init_addr_reg;
        if (init_addr_reg == LAST_ADDR) begin
          state_next = IDLE;
        end else begin
          init_addr_next = init_addr_reg + 1'b1;
        end
      end else begin
        if (rd_req && !(starved && wr_req)) begin
          rd_grant   = 1'b1;
          state_next = RD;
          ram_re     = rd_in_range;
          ram_addr   = rd_addr;
        end else if (wr_req) begin
          wr_grant   = 1'b1;
          state_next = WR;
          ram_we     = wr_in_range;
          ram_addr   = wr_addr;
          ram_wdata  = wr_data;
          rd_miss    = rd_req;
        end else begin
          state_next = IDLE;
        end

        if (wr_grant) begin
          starve_next = '0;
        end else if (wr_req && !starved) begin
          starve_next = starve_reg + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= INIT;
      init_addr_reg <= '0;
      starve_reg    <= '0;
      rd_p1_reg     <= 1'b0;
      rd_oor_p1_reg <= 1'b0;
      rd_valid_reg  <= 1'b0;
      rd_data_reg   <= '0;
      wr_ack_reg    <= 1'b0;
      wr_err_reg    <= 1'b0;
      init_done_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      init_addr_reg <= init_addr_next;
      starve_reg    <= starve_next;
      rd_p1_reg     <= rd_grant;
      rd_oor_p1_reg <= rd_grant && !rd_in_range;
      rd_valid_reg  <= rd_p1_reg;
      if (rd_p1_reg) begin
        rd_data_reg <= rd_oor_p1_reg ? CELL_FREE : ram_q;
      end
      wr_ack_reg <= wr_grant;
      wr_err_reg <= wr_grant && !wr_in_range;
      if (state_reg == INIT && state_next == IDLE) begin
        init_done_reg <= 1'b1;
      end
    end
  end

  // Pose fields: index 2 = x, 1 = y, 0 = heading. Commit takes the pending
  // value as it stood before any same-cycle pose_wr.
  logic [2:0][3:0] pose_in;
  logic [2:0][3:0] pose_cmt;

  assign pose_in = {pose_x, pose_y, pose_d};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_pose
      logic [3:0] pend_reg;
      logic [3:0] cmt_reg;

      always_ff @(posedge clk) begin
        if (!rst) begin
          pend_reg <= '0;
          cmt_reg  <= '0;
        end else begin
          if (pose_wr) begin
            pend_reg <= pose_in[gi];
          end
          if (frame_start) begin
            cmt_reg <= pend_reg;
          end
        end
      end

      assign pose_cmt[gi] = cmt_reg;
    end
  endgenerate

  assign xr_o      = pose_cmt[2];
  assign yr_o      = pose_cmt[1];
  assign dr_o      = pose_cmt[0];
  assign rd_valid  = rd_valid_reg;
  assign rd_data   = rd_data_reg;
  assign wr_ack    = wr_ack_reg;
  assign wr_err    = wr_err_reg;
  assign init_done = init_done_reg;

endmodule

// File: tb/tb_map_access_arbiter.sv
// Randomized bench for map_access_arbiter against a transaction-level model of
// the map contents, arbitration rules and pose double-buffering.
module tb_map_access_arbiter;

  localparam int STARVE = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rd_req = 1'b0;
  logic [3:0] rd_row = '0;
  logic [4:0] rd_col = '0;
  logic       rd_valid, rd_miss, wr_ack, wr_err, init_done;
  logic [3:0] rd_data, xr_o, yr_o, dr_o;
  logic       wr_req = 1'b0;
  logic [3:0] wr_row = '0;
  logic [4:0] wr_col = '0;
  logic [3:0] wr_data = '0;
  logic       pose_wr = 1'b0, frame_start = 1'b0;
  logic [3:0] pose_x = '0, pose_y = '0, pose_d = '0;

  map_access_arbiter dut (
    .clk(clk), .rst(rst),
    .rd_req(rd_req), .rd_row(rd_row), .rd_col(rd_col),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_miss(rd_miss),
    .wr_req(wr_req), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
    .wr_ack(wr_ack), .wr_err(wr_err),
    .pose_wr(pose_wr), .pose_x(pose_x), .pose_y(pose_y), .pose_d(pose_d),
    .frame_start(frame_start),
    .xr_o(xr_o), .yr_o(yr_o), .dr_o(dr_o), .init_done(init_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         stamp;
    logic [3:0] val;
  } exp_t;

  int         err_cnt = 0;
  int         chk_cnt = 0;
  int         cyc = 0;
  int         lost = 0;
  int         ack_cyc = -1;
  int         miss_cnt = 0;
  int         cmt_stamp = -1;
  logic [3:0] mem_m [200];
  exp_t       rd_q[$];
  exp_t       wr_q[$];
  logic [3:0] last_rd = '0;
  logic [11:0] pend_m = '0, cmt_m = '0, cmt_val = '0, pose_g = '0;
  bit         pw_g = 0, fs_g = 0;
  bit         wr_pend = 0;
  logic [3:0] wr_r = '0, wr_d = '0;
  logic [4:0] wr_c = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit in_map(input logic [3:0] r, input logic [4:0] c);
    return (r < 10) && (c < 20);
  endfunction

  task automatic post_write(input logic [3:0] r, input logic [4:0] c, input logic [3:0] d);
    wr_pend = 1;
    wr_r = r;
    wr_c = c;
    wr_d = d;
  endtask

  task automatic clear_model();
    lost = 0;
    rd_q.delete();
    wr_q.delete();
    for (int i = 0; i < 200; i++) mem_m[i] = '0;
    last_rd = '0;
    pend_m = '0;
    cmt_m = '0;
    cmt_stamp = -1;
    wr_pend = 0;
    pw_g = 0;
    fs_g = 0;
  endtask

  // One clock cycle: check what the model expects now, drive, then predict.
  task automatic step(input bit rq, input logic [3:0] rr, input logic [4:0] rc);
    bit   starved, rd_g, wr_g;
    logic [1:0] ew;
    exp_t e;
    @(negedge clk);
    cyc++;
    if (cmt_stamp == cyc) cmt_m = cmt_val;

    ew = 2'b00;
    if (wr_q.size() > 0 && wr_q[0].stamp == cyc) begin
      e = wr_q.pop_front();
      ew = {1'b1, e.val[0]};
      $display("WR  cyc=%0d ack err=%0b", cyc, e.val[0]);
    end
    check_eq("wr_ack_err", {30'b0, wr_ack, wr_err}, {30'b0, ew});
    if (wr_ack) ack_cyc = cyc;

    if (rd_q.size() > 0 && rd_q[0].stamp == cyc) begin
      e = rd_q.pop_front();
      last_rd = e.val;
      check_eq("rd_valid", rd_valid, 1);
      $display("RD  cyc=%0d data=%0d", cyc, e.val);
    end else begin
      check_eq("rd_valid", rd_valid, 0);
    end
    check_eq("rd_data", rd_data, last_rd);
    check_eq("pose", {xr_o, yr_o, dr_o}, cmt_m);

    rd_req = rq;
    rd_row = rr;
    rd_col = rc;
    wr_req = wr_pend;
    wr_row = wr_r;
    wr_col = wr_c;
    wr_data = wr_d;
    pose_wr = pw_g;
    {pose_x, pose_y, pose_d} = pose_g;
    frame_start = fs_g;
    #1;

    starved = (lost >= STARVE);
    rd_g = rq && !(starved && wr_pend);
    wr_g = !rd_g && wr_pend;
    check_eq("rd_miss", rd_miss, rq && wr_pend && starved);
    if (rd_miss) miss_cnt++;
    if (rd_g) begin
      e.stamp = cyc + 2;
      e.val = in_map(rr, rc) ? mem_m[int'(rr) * 20 + int'(rc)] : 4'd0;
      rd_q.push_back(e);
    end
    if (wr_g) begin
      e.stamp = cyc + 1;
      e.val = in_map(wr_r, wr_c) ? 4'd0 : 4'd1;
      wr_q.push_back(e);
      if (in_map(wr_r, wr_c)) mem_m[int'(wr_r) * 20 + int'(wr_c)] = wr_d;
      wr_pend = 0;
      lost = 0;
    end else if (wr_pend && lost < STARVE) begin
      lost++;
    end
    if (fs_g) begin
      cmt_stamp = cyc + 1;
      cmt_val = pend_m;
    end
    if (pw_g) pend_m = pose_g;
    pw_g = 0;
    fs_g = 0;
  endtask

  task automatic do_reset(input bit keep_wr, input bit abort_init);
    int cnt;
    int bad;
    @(negedge clk);
    rst = 1'b0;
    rd_req = 1'b0;
    pose_wr = 1'b0;
    frame_start = 1'b0;
    wr_req = keep_wr;
    wr_row = wr_r;
    wr_col = wr_c;
    wr_data = wr_d;
    @(negedge clk);
    wr_req = 1'b0;
    check_eq("rst_outputs", {rd_valid, rd_miss, wr_ack, wr_err, init_done, rd_data, xr_o, yr_o, dr_o}, 0);
    clear_model();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    if (abort_init) begin
      repeat (60) @(negedge clk);
      check_eq("init_done_early", init_done, 0);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
    end
    cnt = 0;
    bad = 0;
    while (!init_done && cnt < 400) begin
      rd_req = (cnt < 150);
      wr_req = (cnt < 150);
      rd_row = 4'd1;
      rd_col = 5'd1;
      wr_row = 4'd1;
      wr_col = 5'd1;
      wr_data = 4'd5;
      @(posedge clk);
      cnt++;
      #1;
      if (rd_valid || wr_ack) bad++;
    end
    rd_req = 1'b0;
    wr_req = 1'b0;
    check_eq("init_cycles", cnt, 200);
    check_eq("acks_during_init", bad, 0);
    $display("RST init_done after %0d cycles", cnt);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    clear_model();
    do_reset(0, 0);

    // Corner cell reads as cleared
    step(1, 4'd9, 5'd19);
    repeat (3) step(0, 0, 0);

    // In-range write then read back
    post_write(4'd3, 5'd7, 4'd5);
    repeat (2) step(0, 0, 0);
    step(1, 4'd3, 5'd7);
    repeat (3) step(0, 0, 0);
    check_eq("rd_3_7", rd_data, 5);

    // Out-of-range write rejected, out-of-range read returns 0
    post_write(4'd10, 5'd0, 4'd2);
    repeat (2) step(0, 0, 0);
    step(1, 4'd10, 5'd0);
    repeat (3) step(0, 0, 0);
    check_eq("rd_oor", rd_data, 0);

    // Starvation: reads every cycle, pending write forced after 64 losses
    post_write(4'd2, 5'd2, 4'd4);
    start = cyc + 1;
    miss_cnt = 0;
    ack_cyc = -1;
    for (int i = 0; i < 70; i++) begin
      step(1, 4'($urandom_range(0, 9)), 5'($urandom_range(0, 19)));
    end
    check_eq("starve_ack_lat", ack_cyc - start, 65);
    check_eq("miss_count", miss_cnt, 1);
    step(1, 4'd2, 5'd2);
    repeat (3) step(0, 0, 0);
    check_eq("rd_2_2", rd_data, 4);

    // Pose double-buffering
    pose_g = {4'd4, 4'd2, 4'd3};
    pw_g = 1;
    step(0, 0, 0);
    repeat (3) step(0, 0, 0);
    check_eq("pose_hold", {xr_o, yr_o, dr_o}, 0);
    fs_g = 1;
    step(0, 0, 0);
    step(0, 0, 0);
    check_eq("pose_commit", {xr_o, yr_o, dr_o}, 12'h423);
    pose_g = {4'd7, 4'd7, 4'd1};
    pw_g = 1;
    step(0, 0, 0);
    pose_g = {4'd1, 4'd1, 4'd0};
    pw_g = 1;
    fs_g = 1;
    step(0, 0, 0);
    step(0, 0, 0);
    check_eq("pose_same_cycle", {xr_o, yr_o, dr_o}, 12'h771);
    fs_g = 1;
    step(0, 0, 0);
    step(0, 0, 0);
    check_eq("pose_next_frame", {xr_o, yr_o, dr_o}, 12'h110);

    // Random interleaved traffic
    for (int i = 0; i < 800; i++) begin
      if (!wr_pend && $urandom_range(0, 2) == 0)
        post_write(4'($urandom_range(0, 10)), 5'($urandom_range(0, 20)), 4'($urandom_range(0, 5)));
      if ($urandom_range(0, 9) == 0) begin
        pw_g = 1;
        pose_g = 12'($urandom);
      end
      if ($urandom_range(0, 19) == 0) fs_g = 1;
      step($urandom_range(0, 9) < 6, 4'($urandom_range(0, 11)), 5'($urandom_range(0, 21)));
    end
    repeat (4) step(0, 0, 0);

    // Reset with a write being granted: no ack, map cleared again
    post_write(4'd5, 5'd5, 4'd3);
    do_reset(1, 0);
    step(0, 0, 0);
    step(1, 4'd5, 5'd5);
    repeat (3) step(0, 0, 0);
    check_eq("rd_after_rst", rd_data, 0);

    // Reset in the middle of the clear sequence restarts it
    do_reset(0, 1);
    for (int i = 0; i < 200; i++) begin
      if (!wr_pend && $urandom_range(0, 2) == 0)
        post_write(4'($urandom_range(0, 10)), 5'($urandom_range(0, 20)), 4'($urandom_range(0, 5)));
      step($urandom_range(0, 1) == 1, 4'($urandom_range(0, 10)), 5'($urandom_range(0, 20)));
    end
    repeat (4) step(0, 0, 0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/map_access_arbiter.md
Name: map_access_arbiter

Overview:
- Owns the 10x20 map RAM (4-bit cells, codes 0..5) and the robot pose registers for the display path.
- Shares one single-port RAM between two requesters: the VGA renderer (read port, high priority) and the robot/map update logic (write port, low priority, with a starvation guard).
- Clears the map after reset.
- Double-buffers robot pose (xr, yr, dr) and commits it only at frame start, so the display never tears mid-frame.

Parameters:
- ROWS, 10, map rows.
- COLS, 20, map columns.
- CELL_W, 4, bits per map cell.
- STARVE_LIMIT, 64, consecutive cycles a pending write may lose arbitration before it is forced through.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset.
- rd_req  in  1  display read request; pulse or level, one access per cycle.
- rd_row  in  4  display row.
- rd_col  in  5  display column.
- rd_valid  out  1  rd_data valid this cycle.
- rd_data  out  4  cell code read.
- rd_miss  out  1  pulse; a read request was dropped because of a forced write.
- wr_req  in  1  update write request; held high until wr_ack.
- wr_row  in  4  write row.
- wr_col  in  5  write column.
- wr_data  in  4  cell code to write.
- wr_ack  out  1  one-cycle pulse; write completed or rejected.
- wr_err  out  1  valid with wr_ack; coordinates out of range, no write performed.
- pose_wr  in  1  load pending pose.
- pose_x  in  4  pending robot x.
- pose_y  in  4  pending robot y.
- pose_d  in  4  pending orientation (0 N, 1 W, 2 S, 3 E).
- frame_start  in  1  one-cycle pulse at start of vertical blank.
- xr_o  out  4  committed robot x.
- yr_o  out  4  committed robot y.
- dr_o  out  4  committed orientation.
- init_done  out  1  high once map clear finishes.

Behaviour:
- Address: addr = row*COLS + col, 8 bits, range 0..199. A coordinate is out of range when row >= ROWS or col >= COLS.
- Reset (rst low at a clk edge) forces state INIT and clears:
  - outputs rd_valid, rd_miss, wr_ack, wr_err, init_done, rd_data, xr_o, yr_o, dr_o to 0;
  - pending pose and starvation counter to 0.
- Reset mid-operation aborts any access in flight; no wr_ack is issued for it.
- FSM states INIT, IDLE, RD, WR.
  - INIT: writes 0 to addr 0..199, one per cycle (200 cycles), then goes to IDLE and sets init_done. Requests are ignored, with no ack and no rd_valid.
  - IDLE/RD/WR: each cycle the arbiter issues at most one RAM access.
- Arbitration in IDLE/RD/WR:
  - rd_req high and starve counter < STARVE_LIMIT: issue read (state RD).
  - Otherwise, wr_req high: issue write (state WR).
- Starve counter:
  - Increments each cycle wr_req is high and not granted; saturates at STARVE_LIMIT.
  - Clears on wr_ack.
  - When the counter equals STARVE_LIMIT and rd_req and wr_req are both high, the write wins and rd_miss pulses for that cycle.
- Read latency: rd_req accepted in cycle N gives rd_valid high in cycle N+2 with rd_data (RAM registered address plus registered output). rd_data holds its last value when rd_valid is low.
- Out-of-range read: no RAM access; rd_valid at N+2 with rd_data = 0.
- Write: grant in cycle N performs the RAM write at the end of cycle N; wr_ack pulses in cycle N+1.
  - The requester drops wr_req after seeing wr_ack. wr_req still high in cycle N+1 is a new request.
  - Out-of-range write: wr_ack and wr_err at N+1, RAM unchanged.
- Read-after-write to the same address: a read accepted in the cycle after the write sees the new data (RAM write-first is not required; the write is already complete).
- Pose:
  - pose_wr loads the pending registers. The last pose_wr wins.
  - frame_start copies pending to xr_o/yr_o/dr_o in the next cycle.
  - pose_wr and frame_start in the same cycle: the commit uses the old pending value; the new value is committed at the next frame_start.
  - No range check on pose values.

Decomposition:
- Shared package map_pkg:
  - ROWS, COLS, CELL_W;
  - cell code constants (CELL_FREE 0, CELL_WALL 1, CELL_BLACK 2, CELL_DEBRIS_L 3, CELL_DEBRIS_M 4, CELL_DEBRIS_H 5);
  - orientation constants (DIR_N 0, DIR_W 1, DIR_S 2, DIR_E 3);
  - FSM state encoding.
- Sub-module map_ram: 200x4 single-port synchronous RAM, registered read, write enable. Inferable as block RAM.

Test Plan:
- Reset then idle 205 cycles -> init_done rises exactly 200 cycles after rst goes high; a read of (9,19) returns rd_data 0, rd_valid 2 cycles after rd_req.
- Write (3,7)=5, then read (3,7) -> wr_ack 1 cycle after grant with wr_err 0; read returns 5 at N+2. A write to (10,0) -> wr_ack with wr_err 1, and a read of addr 200 is never issued.
- rd_req held high continuously with wr_req high -> write is forced exactly after 64 lost cycles; rd_miss pulses once in that cycle; counter is then cleared and reads resume.
- pose_wr (4,2,3) mid-frame -> xr_o/yr_o/dr_o unchanged until 1 cycle after frame_start, then 4/2/3. pose_wr (1,1,0) coincident with frame_start -> commits the previous pending value.
- Deassert rst while a write is in flight and during INIT -> no wr_ack; outputs return to 0; INIT restarts from addr 0.
- Random interleaved rd/wr traffic vs. a scoreboard model -> every rd_data matches the last acked write (or 0); no lost or duplicated acks.
